// File: rtl/fpga_spram_pipe_if.sv
// Request/response bundle for fpga_spram_pipe.
// The memory bridge drives the master side and the RAM drives the slave side.
interface fpga_spram_pipe_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int WEA_SIZE = DATA_WIDTH / BYTE_WIDTH;

  logic                  ena;
  logic [ADDR_WIDTH-1:0] addra;
  logic [WEA_SIZE-1:0]   wea;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  logic                  dvalid;
  logic                  init_busy;

  modport master (output ena, addra, wea, dina, input douta, dvalid, init_busy);
  modport slave  (input ena, addra, wea, dina, output douta, dvalid, init_busy);
endinterface

// File: rtl/fpga_spram_pipe.sv
// Single-port synchronous RAM with byte enables, 1..3 cycle read pipeline,
// selectable write-collision behaviour and an optional post-reset clear sequencer.
module fpga_spram_pipe #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clka,
  input  logic             rsta,
  fpga_spram_pipe_if.slave bus
);
  localparam int WEA_SIZE = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CLEAR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_IDLE} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   clear_count;
  logic                  clear_we;
  logic                  busy;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  accept;
  logic                  is_write;
  logic                  launch;

  logic [DATA_WIDTH-1:0] stage_data  [READ_LATENCY];
  logic                  stage_valid [READ_LATENCY];

  // The counter is one bit wider than the address so the last clear write cannot alias address 0.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state       <= ST_RST;
      clear_count <= '0;
    end else begin
      state <= state_next;
      if (clear_we) begin
        clear_count <= clear_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RST:   state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: if (clear_count == CLEAR_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Address 0 is written on the first edge after reset release, while still in ST_RST.
  always_comb begin
    busy     = 1'b0;
    clear_we = 1'b0;
    if (CLEAR_ON_RESET != 0) begin
      busy     = (state != ST_IDLE);
      clear_we = busy && !rsta;
    end
  end

  assign accept   = bus.ena && !busy && !rsta;
  assign is_write = |bus.wea;
  assign old_word = mem[bus.addra];
  assign launch   = accept && !(is_write && WRITE_MODE == 2);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < WEA_SIZE; i++) begin
      if (bus.wea[i]) begin
        merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Array storage has no reset so it maps onto block RAM; only the clear sequencer zeroes it.
  always_ff @(posedge clka) begin
    if (clear_we) begin
      mem[clear_count[ADDR_WIDTH-1:0]] <= '0;
    end else if (accept) begin
      for (int i = 0; i < WEA_SIZE; i++) begin
        if (bus.wea[i]) begin
          mem[bus.addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Data registers only move with their valid bit so douta holds between results.
  always_ff @(posedge clka) begin
    if (rsta) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_valid[i] <= 1'b0;
        stage_data[i]  <= '0;
      end
    end else begin
      stage_valid[0] <= launch;
      if (launch) begin
        stage_data[0] <= (is_write && WRITE_MODE == 0) ? merged_word : old_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        if (stage_valid[i-1]) begin
          stage_data[i] <= stage_data[i-1];
        end
      end
    end
  end

  assign bus.douta     = stage_data[READ_LATENCY-1];
  assign bus.dvalid    = stage_valid[READ_LATENCY-1];
  assign bus.init_busy = busy;
endmodule

// File: tb/tb_fpga_spram_pipe.sv
// Three fpga_spram_pipe configurations share one stimulus stream and are checked every
// cycle against a schedule-based reference model, plus directed tables and sequences.
module tb_fpga_spram_pipe;
  localparam int DEPTH = 64;
  localparam int N     = 3;
  localparam int LAT0 = 1, LAT1 = 3, LAT2 = 2;
  localparam int MODE0 = 0, MODE1 = 1, MODE2 = 2;
  localparam int CLR0 = 1, CLR1 = 1, CLR2 = 0;

  typedef struct {
    bit          e;
    logic [5:0]  a;
    logic [3:0]  w;
    logic [31:0] d;
    bit          xv;
    logic [31:0] xq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [5:0]  addr;
  logic [3:0]  wea;
  logic [31:0] din;

  int checks = 0;
  int errors = 0;

  logic        dv [N];
  logic [31:0] dq [N];
  logic        bz [N];

  fpga_spram_pipe_if bus0 ();
  fpga_spram_pipe_if bus1 ();
  fpga_spram_pipe_if bus2 ();

  assign bus0.ena = ena;  assign bus0.addra = addr;  assign bus0.wea = wea;  assign bus0.dina = din;
  assign bus1.ena = ena;  assign bus1.addra = addr;  assign bus1.wea = wea;  assign bus1.dina = din;
  assign bus2.ena = ena;  assign bus2.addra = addr;  assign bus2.wea = wea;  assign bus2.dina = din;
  assign dv[0] = bus0.dvalid;  assign dq[0] = bus0.douta;  assign bz[0] = bus0.init_busy;
  assign dv[1] = bus1.dvalid;  assign dq[1] = bus1.douta;  assign bz[1] = bus1.init_busy;
  assign dv[2] = bus2.dvalid;  assign dq[2] = bus2.douta;  assign bz[2] = bus2.init_busy;

  fpga_spram_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(LAT0),
                    .WRITE_MODE(MODE0), .CLEAR_ON_RESET(CLR0))
    u0 (.clka(clk), .rsta(rst), .bus(bus0));
  fpga_spram_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(LAT1),
                    .WRITE_MODE(MODE1), .CLEAR_ON_RESET(CLR1))
    u1 (.clka(clk), .rsta(rst), .bus(bus1));
  fpga_spram_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(LAT2),
                    .WRITE_MODE(MODE2), .CLEAR_ON_RESET(CLR2))
    u2 (.clka(clk), .rsta(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    case (i)
      0:       return LAT0;
      1:       return LAT1;
      default: return LAT2;
    endcase
  endfunction

  function automatic int mode_of(input int i);
    case (i)
      0:       return MODE0;
      1:       return MODE1;
      default: return MODE2;
    endcase
  endfunction

  function automatic int clr_of(input int i);
    case (i)
      0:       return CLR0;
      1:       return CLR1;
      default: return CLR2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit e, input logic [5:0] a, input logic [3:0] w,
                               input logic [31:0] d);
    ena  = e;
    addr = a;
    wea  = w;
    din  = d;
  endtask

  // Reference model: word array, clear countdown, and results scheduled by arrival cycle.
  logic [31:0] mdl_mem    [N][DEPTH];
  int          clear_left [N];
  bit          ring_v     [N][8];
  logic [31:0] ring_d     [N][8];
  bit          exp_v      [N];
  logic [31:0] exp_q      [N];
  int          cyc      = 0;
  bit          model_on = 1'b0;

  task automatic modelStep();
    logic [31:0] old_w;
    logic [31:0] new_w;
    int          slot;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        clear_left[i] = (clr_of(i) != 0) ? DEPTH : 0;
        for (int s = 0; s < 8; s++) ring_v[i][s] = 1'b0;
        exp_v[i] = 1'b0;
        exp_q[i] = '0;
      end else begin
        if (clear_left[i] > 0) begin
          mdl_mem[i][DEPTH - clear_left[i]] = '0;
          clear_left[i]--;
        end else if (ena) begin
          old_w = mdl_mem[i][addr];
          new_w = old_w;
          for (int b = 0; b < 4; b++) begin
            if (wea[b]) new_w[b*8 +: 8] = din[b*8 +: 8];
          end
          mdl_mem[i][addr] = new_w;
          slot = (cyc + lat_of(i) - 1) % 8;
          if (wea == 4'h0 || mode_of(i) == 1) begin
            ring_v[i][slot] = 1'b1;
            ring_d[i][slot] = old_w;
          end else if (mode_of(i) == 0) begin
            ring_v[i][slot] = 1'b1;
            ring_d[i][slot] = new_w;
          end
        end
        slot     = cyc % 8;
        exp_v[i] = ring_v[i][slot];
        if (ring_v[i][slot]) exp_q[i] = ring_d[i][slot];
        ring_v[i][slot] = 1'b0;
      end
    end
    cyc++;
  endtask

  always @(posedge clk) begin
    if (model_on) begin
      modelStep();
      #1;
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("model_dvalid_u%0d", i), {31'd0, dv[i]}, {31'd0, exp_v[i]});
        checkOutput($sformatf("model_douta_u%0d", i), dq[i], exp_q[i]);
        checkOutput($sformatf("model_busy_u%0d", i), {31'd0, bz[i]}, {31'd0, clear_left[i] > 0});
      end
    end
  end

  // Called at the negedge where reset has just been released; counts edges until busy drops.
  task automatic waitClear(input string name, input int expected);
    int cnt = 0;
    while (bz[0] && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput(name, cnt, expected);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t        tbl [8];
    logic        s_v [12];
    logic [31:0] s_q [12];
    logic        m_v [4][3];
    logic [31:0] m_q [4][3];

    tbl[0] = '{1'b1, 6'd5, 4'hF, 32'h11223344, 1'b1, 32'h11223344};
    tbl[1] = '{1'b1, 6'd5, 4'h5, 32'hAABBCCDD, 1'b1, 32'h11BB33DD};
    tbl[2] = '{1'b1, 6'd5, 4'h0, 32'h00000000, 1'b1, 32'h11BB33DD};
    tbl[3] = '{1'b1, 6'd3, 4'hF, 32'h0000CAFE, 1'b1, 32'h0000CAFE};
    tbl[4] = '{1'b0, 6'd0, 4'h0, 32'h00000000, 1'b0, 32'h0000CAFE};
    tbl[5] = '{1'b1, 6'd3, 4'hF, 32'h12345678, 1'b1, 32'h12345678};
    tbl[6] = '{1'b1, 6'd3, 4'h0, 32'h00000000, 1'b1, 32'h12345678};
    tbl[7] = '{1'b1, 6'd5, 4'h0, 32'h00000000, 1'b1, 32'h11BB33DD};

    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, '0);
    model_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    waitClear("clear_initial_cycles", 64);

    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 6'(a), 4'hF, 32'hDEADBEEF);
      @(negedge clk);
    end
    applyStimulus(1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    pulseReset();
    waitClear("clear_after_preload_cycles", 64);

    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 6'(a), 4'h0, '0);
      @(negedge clk);
      checkOutput($sformatf("clear_read_dvalid_a%0d", a), {31'd0, dv[0]}, 32'd1);
      checkOutput($sformatf("clear_read_douta_a%0d", a), dq[0], 32'h0);
    end

    for (int k = 0; k < 8; k++) begin
      applyStimulus(tbl[k].e, tbl[k].a, tbl[k].w, tbl[k].d);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_dvalid", k), {31'd0, dv[0]}, {31'd0, tbl[k].xv});
      checkOutput($sformatf("vec%0d_douta", k), dq[0], tbl[k].xq);
    end
    applyStimulus(1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);

    // Write-mode collision: mem[3]=CAFE, then overwrite with 12345678 and watch all three modes.
    applyStimulus(1'b1, 6'd3, 4'hF, 32'h0000CAFE);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 6'd3, 4'hF, 32'h12345678);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, '0);
      for (int i = 0; i < N; i++) begin
        m_v[j][i] = dv[i];
        m_q[j][i] = dq[i];
      end
    end
    checkOutput("mode0_dvalid", {31'd0, m_v[0][0]}, 32'd1);
    checkOutput("mode0_douta", m_q[0][0], 32'h12345678);
    checkOutput("mode1_dvalid", {31'd0, m_v[2][1]}, 32'd1);
    checkOutput("mode1_douta", m_q[2][1], 32'h0000CAFE);
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("mode2_dvalid_c%0d", j), {31'd0, m_v[j][2]}, 32'd0);
      checkOutput($sformatf("mode2_douta_c%0d", j), m_q[j][2], 32'h11BB33DD);
    end

    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b1, 6'(a), 4'hF, 32'(a));
      @(negedge clk);
    end
    applyStimulus(1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 6'd0, 4'h0, '0);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      s_v[j] = dv[1];
      s_q[j] = dq[1];
      if (j + 1 < 8) applyStimulus(1'b1, 6'(j + 1), 4'h0, '0);
      else           applyStimulus(1'b0, '0, '0, '0);
    end
    for (int j = 0; j < 12; j++) begin
      checkOutput($sformatf("stream_dvalid_c%0d", j), {31'd0, s_v[j]}, {31'd0, (j >= 2 && j <= 9)});
      if (j >= 2 && j <= 9) checkOutput($sformatf("stream_douta_c%0d", j), s_q[j], 32'(j - 2));
    end

    pulseReset();
    applyStimulus(1'b1, 6'd63, 4'hF, 32'hFFFFFFFF);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checkOutput($sformatf("busy_drop_dvalid_c%0d", j), {31'd0, dv[0]}, 32'd0);
    end
    applyStimulus(1'b0, '0, '0, '0);
    waitClear("clear_with_requests_cycles", 54);
    applyStimulus(1'b1, 6'd63, 4'h0, '0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("busy_drop_read_dvalid", {31'd0, dv[0]}, 32'd1);
    checkOutput("busy_drop_read_douta", dq[0], 32'h0);
    repeat (3) @(negedge clk);

    pulseReset();
    repeat (20) @(negedge clk);
    pulseReset();
    waitClear("clear_restart_cycles", 64);

    applyStimulus(1'b1, 6'd1, 4'h0, '0);
    @(negedge clk);
    applyStimulus(1'b1, 6'd2, 4'h0, '0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, '0);
    pulseReset();
    checkOutput("inflight_dvalid_c0", {31'd0, dv[1]}, 32'd0);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      checkOutput($sformatf("inflight_dvalid_c%0d", j), {31'd0, dv[1]}, 32'd0);
    end
    waitClear("clear_after_inflight_cycles", 61);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      applyStimulus($urandom_range(0, 3) != 0,
                    6'($urandom_range(0, (n % 2 == 1) ? 63 : 7)),
                    ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                    $urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    repeat (5) @(negedge clk);
    model_on = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpga_spram_pipe.md
# fpga_spram_pipe

Parametrised single-port synchronous RAM for the Cortex-M0 MCU FPGA build. It is the next generation of the single-port RAM wrapper and adds four things: a selectable read latency of 1–3 cycles, selectable write-collision mode, byte-enable writes, and an optional hardware clear sequencer that zeroes the array after reset. It sits behind the AHB memory bridges (code/data SRAM) and is inferred from behavioural RTL, not vendor macros.

## Interface
- ADDR_WIDTH, 6: address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane; WEA_SIZE = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1: cycles from accepted request to douta/dvalid; legal values 1..3.
- WRITE_MODE, 0: 0 = write_first, 1 = read_first, 2 = no_change.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = contents untouched.
- clka, in, 1: the single clock, rising edge.
- rsta, in, 1: synchronous active-high reset.
- ena, in, 1: access request.
- addra, in, ADDR_WIDTH: word address.
- wea, in, WEA_SIZE: byte write enables; all zero means read.
- dina, in, DATA_WIDTH: write data.
- douta, out, DATA_WIDTH: read data.
- dvalid, out, 1: one-cycle pulse marking new douta.
- init_busy, out, 1: clear sequencer active; requests are dropped while it is high.

## Operation
- **Accept condition:** a request is accepted at an edge where ena=1, init_busy=0 and rsta=0.
- **Write:** each lane i with wea[i]=1 writes dina[i*BYTE_WIDTH +: BYTE_WIDTH] to mem[addra]. Lanes with wea[i]=0 keep their old bytes.
- **Read (wea=0):** returns mem[addra] and generates dvalid.
- **Write with WRITE_MODE=0:** returns the merged new word and generates dvalid.
- **Write with WRITE_MODE=1:** returns the pre-write word and generates dvalid.
- **Write with WRITE_MODE=2:** no dvalid; douta holds its value.
- **douta hold:** douta holds its last value whenever no dvalid is produced. It is never X after reset.
- **Pipeline:** the array read register is followed by READ_LATENCY-1 output registers. Each stage carries a valid bit, and the final stage's valid bit drives dvalid. Back-to-back accepted requests stream at one per cycle.
- **Clear sequencer** (CLEAR_ON_RESET=1):
  - States: RST → CLEAR → IDLE.
  - RST: held while rsta=1; clear counter = 0.
  - CLEAR: writes all-zero to mem[counter] each cycle, counter+1. The write at counter = 2**ADDR_WIDTH-1 moves to IDLE.
  - IDLE: normal operation.
  - The counter is ADDR_WIDTH+1 bits wide so it cannot wrap early.
- **CLEAR_ON_RESET=0:** the sequencer goes straight to IDLE and init_busy is constant 0 after reset.
- **Requests during CLEAR** are discarded: no write, no dvalid, nothing queued.
- **Reset mid-operation:**
  - All pipeline valid bits clear and in-flight reads are lost.
  - A clear in progress restarts from address 0.
  - Array contents are not reset except by the clear itself.
- **Reset values:**
  - douta = 0, dvalid = 0.
  - init_busy = CLEAR_ON_RESET.
  - Clear counter = 0, all pipeline valid bits = 0.

## Timing
- **Read/write latency:** request accepted at edge k gives douta/dvalid registered at edge k+READ_LATENCY-1, visible for the following cycle.
  - L=1: classic BRAM behaviour, data one cycle after the address.
  - L=3: two extra cycles.
- **dvalid:** high exactly one cycle per qualifying request. Continuous requests give continuous dvalid.
- **Read-after-write, same address, next cycle:** returns the written data in all modes.
- **Clear timing:** rsta is sampled low at edge 0. Edges 0..DEPTH-1 write addresses 0..DEPTH-1. init_busy falls after edge DEPTH-1, so the first acceptable request is at edge DEPTH, and clear takes exactly DEPTH cycles.
- **Reset timing:** rsta=1 at edge k forces dvalid=0 from edge k on, including results already in the pipeline.

## Test plan
- **Clear then read:** defaults, clear on. Preload mem via backdoor with 0xDEADBEEF, pulse rsta one cycle, wait until init_busy=0 (exactly 64 cycles). Read addresses 0..63 → all douta=0x00000000. dvalid appears 1 cycle after each request.
- **Byte lanes:** write 0x11223344 to addr 5 with wea=4'hF, then 0xAABBCCDD with wea=4'b0101, then read addr 5 → 0x11BB33DD.
- **Write modes:** mem[3]=0x0000CAFE. Write 0x12345678 to addr 3:
  - Mode 0 → douta=0x12345678 with dvalid.
  - Mode 1 → douta=0x0000CAFE with dvalid.
  - Mode 2 → no dvalid, douta unchanged.
- **Latency and streaming:** READ_LATENCY=3. Issue reads of addrs 0..7 back-to-back, which contain their own index. → dvalid is high for 8 consecutive cycles starting 3 cycles after the first request, and douta = 0..7 in order.
- **Requests during clear:** assert ena with wea=4'hF, dina=0xFFFFFFFF, addr 63, while init_busy=1. → no dvalid, and after clear mem[63] reads 0.
- **Reset mid-operation:** assert rsta at clear counter=20, and in a second run with 2 reads in flight at READ_LATENCY=3. → the clear restarts (init_busy high another 64 cycles after release), and no dvalid is produced for the in-flight reads.
